// File: rtl/apb2_pkg.sv
// Shared types and constants for the two-slave APB requester.
// Build option: APB_TIMEOUT_EN enables the ACCESS wait timeout.
package apb2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic SEL_S1 = 1'b0;
  localparam logic SEL_S2 = 1'b1;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait counter; expire is combinational, so the master terminates on the edge the count reaches WAIT_MAX.
// Holds at zero outside ACCESS, so every transfer starts from a clean count.
module apb_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic waiting,
  output logic expire
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + 1'b1;
    end
  end

  assign expire = waiting && (count == LAST);

endmodule

// File: rtl/apb2_master.sv
// One-at-a-time APB requester for two slaves: accept->response in 3 cycles plus slave wait states.
// cmd_ready only in IDLE; optional ACCESS timeout under APB_TIMEOUT_EN.
module apb2_master
  import apb2_pkg::*;
#(
  parameter int ADDR_W   = APB_ADDR_W,
  parameter int DATA_W   = APB_DATA_W,
  parameter int WAIT_MAX = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  state_t            state;
  logic              sel;
  logic              pready_sel;
  logic [DATA_W-1:0] prdata_sel;
  logic              timeout;

  // Only the addressed slave's return path is ever looked at.
  assign pready_sel = (sel == SEL_S2) ? PREADY2 : PREADY1;
  assign prdata_sel = (sel == SEL_S2) ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .run    (state == ACCESS),
    .waiting((state == ACCESS) && !pready_sel),
    .expire (timeout)
  );
`else
  logic [31:0] unused_wait_max;
  assign unused_wait_max = WAIT_MAX;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      sel       <= SEL_S1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= SETUP;
            sel       <= cmd_sel;
            cmd_ready <= 1'b0;
            PSEL1     <= (cmd_sel == SEL_S1);
            PSEL2     <= (cmd_sel == SEL_S2);
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          // A timeout completes like a ready, but flags the error and returns no data.
          if (pready_sel || timeout) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= !pready_sel;
            rsp_rdata <= (pready_sel && !PWRITE) ? prdata_sel : '0;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          PSEL1     <= 1'b0;
          PSEL2     <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb2_master.sv
// Randomized bench for apb2_master: slave memories plus a cycle-level expectation model.
// Build with APB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_apb2_master;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int WAIT_MAX = 15;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL1, PSEL2, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA1, PRDATA2;
  logic              PREADY1, PREADY2;

  apb2_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  // Slave memories (environment) and an independent reference copy (model).
  logic [DATA_W-1:0] s_mem   [2][256];
  logic [DATA_W-1:0] ref_mem [2][256];

  assign PRDATA1 = s_mem[0][PADDR];
  assign PRDATA2 = s_mem[1][PADDR];

  always @(posedge PCLK) begin
    if (PSEL1 && PENABLE && PREADY1 && PWRITE) s_mem[0][PADDR] <= PWDATA;
    if (PSEL2 && PENABLE && PREADY2 && PWRITE) s_mem[1][PADDR] <= PWDATA;
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic              last_wr;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] bus_obs();
    return {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid};
  endfunction

  function automatic logic [21:0] bus_exp(input logic p1, input logic p2, input logic en,
                                          input logic wr, input logic [7:0] a, input logic [7:0] d,
                                          input logic rdy, input logic vld);
    return {p1, p2, en, wr, a, d, rdy, vld};
  endfunction

  always @(negedge PCLK) begin
    if (!PRESET) chk("bus_excl", {PSEL1 & PSEL2, PENABLE & ~(PSEL1 | PSEL2)}, 64'd0);
  end

  task automatic do_reset();
    PRESET = 1'b1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_bus", bus_obs(), bus_exp(0, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    chk("rst_rsp", {rsp_err, rsp_rdata}, 64'd0);
    PRESET = 1'b0;
    last_wr = 1'b0; last_a = '0; last_d = '0;
  endtask

  // Issues one command at a negedge with the DUT idle; w = ACCESS cycles with PREADY low.
  // Ends on the negedge after the response edge; hold keeps cmd_valid asserted.
  task automatic do_cmd(input logic wr, input logic sl, input logic [7:0] a, input logic [7:0] d,
                        input int w, input bit hold);
    bit          to;
    int          rk;
    logic [7:0]  er;
    to = TO_EN && (w >= WAIT_MAX);
    rk = to ? WAIT_MAX + 2 : w + 3;
    er = (to || wr) ? 8'h00 : ref_mem[sl][a];
    if (wr && !to) ref_mem[sl][a] = d;
    chk("accept_rdy", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sl; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK);
    for (int k = 1; k <= rk; k++) begin
      @(negedge PCLK);
      if (k == 1) begin
        // Junk on the command port while busy must be ignored.
        cmd_valid = hold;
        cmd_write = 1'($urandom); cmd_sel = 1'($urandom);
        cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
      end
      if (k < rk) begin
        chk("busy_bus", bus_obs(), bus_exp(sl == 1'b0, sl == 1'b1, k >= 2, wr, a, d, 0, 0));
      end else begin
        chk("done_bus", bus_obs(), bus_exp(0, 0, 0, wr, a, d, 1, 1));
        chk("rsp_data", {rsp_err, rsp_rdata}, {55'd0, to, er});
      end
      PREADY1 = 1'($urandom);
      PREADY2 = 1'($urandom);
      if (k >= 2 && k < rk) begin
        if (sl) PREADY2 = (k - 1 > w);
        else    PREADY1 = (k - 1 > w);
      end
    end
    last_wr = wr; last_a = a; last_d = d;
  endtask

  task automatic idle_chk();
    @(negedge PCLK);
    chk("idle_bus", bus_obs(), bus_exp(0, 0, 0, last_wr, last_a, last_d, 1, 0));
  endtask

  task automatic reset_mid(input logic sl, input logic [7:0] a);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = sl; cmd_addr = a; cmd_wdata = 8'($urandom);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY1 = 1'b0; PREADY2 = 1'b0;
    @(negedge PCLK);
    chk("mid_access_en", {63'd0, PENABLE}, 64'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("abort_bus", bus_obs(), bus_exp(0, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("abort_norsp", bus_obs(), bus_exp(0, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    last_wr = 1'b0; last_a = '0; last_d = '0;
  endtask

  initial begin
    logic [7:0] v;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; PREADY1 = 1'b0; PREADY2 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        v = 8'($urandom);
        s_mem[s][i] <= v;
        ref_mem[s][i] = v;
      end
    end
    do_reset();

    // Write then read back on slave2.
    do_cmd(1'b1, 1'b1, 8'h3C, 8'hA5, 0, 1'b0); idle_chk();
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, 0, 1'b0); idle_chk();
    // Same address on both slaves must not alias.
    do_cmd(1'b1, 1'b0, 8'h3C, 8'h11, 0, 1'b0); idle_chk();
    do_cmd(1'b1, 1'b1, 8'h3C, 8'h22, 0, 1'b0); idle_chk();
    do_cmd(1'b0, 1'b0, 8'h3C, 8'h00, 0, 1'b0); idle_chk();
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, 0, 1'b0); idle_chk();
    // Four wait states on a slave1 read.
    do_cmd(1'b0, 1'b0, 8'h3C, 8'h00, 4, 1'b0); idle_chk();
    // cmd_valid held high across three commands.
    do_cmd(1'b1, 1'b0, 8'h05, 8'h5A, 0, 1'b1);
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, 1, 1'b1);
    do_cmd(1'b0, 1'b0, 8'h05, 8'h00, 0, 1'b0); idle_chk();
    // Reset during ACCESS of a read.
    reset_mid(1'b1, 8'h3C); idle_chk();
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, 0, 1'b0); idle_chk();
`ifdef APB_TIMEOUT_EN
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, WAIT_MAX + 5, 1'b0); idle_chk();
    do_cmd(1'b1, 1'b1, 8'h3C, 8'h77, WAIT_MAX, 1'b0); idle_chk();
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, WAIT_MAX - 1, 1'b0); idle_chk();
    do_cmd(1'b0, 1'b1, 8'h3C, 8'h00, 0, 1'b0); idle_chk();
`endif

    for (int n = 0; n < 150; n++) begin
      int  w;
      bit  hold;
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WAIT_MAX + 2))
                                      : int'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0);
      do_cmd(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), w, hold);
      if (!hold) idle_chk();
    end
    do_cmd(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    idle_chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
